// File: rtl/signal_sequencer_pkg.sv
// Shared encodings for the four-way junction sequencer.
//   light_t : per-road lamp state (red / yellow / green); 2'd3 is never driven
//   road_t  : road index, N=0 E=1 S=2 W=3, wraps W -> N
//   state_t : sequencer FSM state
// Helpers:
//   road_inc  - next road in rotation (mod 4)
//   light_for - lamp value one road shows for a given FSM state / owner road
package signal_sequencer_pkg;

  typedef enum logic [1:0] {
    LT_RED    = 2'd0,
    LT_YELLOW = 2'd1,
    LT_GREEN  = 2'd2
  } light_t;

  typedef enum logic [1:0] {
    ROAD_N = 2'd0,
    ROAD_E = 2'd1,
    ROAD_S = 2'd2,
    ROAD_W = 2'd3
  } road_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GREEN  = 2'd1,
    ST_YELLOW = 2'd2,
    ST_ALLRED = 2'd3
  } state_t;

  // Width of the seconds down-counter; TG inputs are 8 bits, so 255 s fits.
  localparam int SEC_W = 8;

  // Two-bit add wraps W back to N on its own.
  function automatic road_t road_inc(input road_t r);
    return road_t'(r + 2'd1);
  endfunction

  // Only the owning road ever leaves red, which keeps the lights one-hot
  // by construction instead of by checking.
  function automatic light_t light_for(input state_t s, input road_t owner,
                                       input road_t me);
    light_t l;
    l = LT_RED;
    if (owner == me) begin
      if (s == ST_GREEN)       l = LT_GREEN;
      else if (s == ST_YELLOW) l = LT_YELLOW;
    end
    return l;
  endfunction

endpackage

// File: rtl/signal_sequencer_if.sv
// Junction bus between the sequencer and the green-time adaptation block.
//   enable                 run request (0 parks the junction in all-red)
//   TGn/TGe/TGs/TGw        green time per road, seconds
//   next_road, load_req    road select toward the adaptation block + change pulse
//   cur_road               road owning green/yellow
//   light_n/e/s/w          lamp outputs
//   cycle_done             pulse when the W green slot ends (served or skipped)
// Modports:
//   master - the sequencer (drives road select, lamps and pulses)
//   slave  - the adaptation side / environment
interface signal_sequencer_if;
  import signal_sequencer_pkg::*;

  logic       enable;
  logic [7:0] TGn;
  logic [7:0] TGe;
  logic [7:0] TGs;
  logic [7:0] TGw;
  road_t      next_road;
  road_t      cur_road;
  light_t     light_n;
  light_t     light_e;
  light_t     light_s;
  light_t     light_w;
  logic       load_req;
  logic       cycle_done;

  modport master (
    input  enable, TGn, TGe, TGs, TGw,
    output next_road, cur_road, light_n, light_e, light_s, light_w,
           load_req, cycle_done
  );

  modport slave (
    output enable, TGn, TGe, TGs, TGw,
    input  next_road, cur_road, light_n, light_e, light_s, light_w,
           load_req, cycle_done
  );

endinterface

// File: rtl/signal_sequencer_prescaler.sv
// sec_prescaler: divides clk down to a one-cycle tick per second.
//   clk   - clock
//   reset - asynchronous active-low reset
//   clr   - synchronous restart; counter is 0 in the cycle after clr
//   tick  - high on the terminal count (TICKS_PER_SEC-1)
// Restarting on every phase entry means a phase of N seconds is exactly
// N*TICKS_PER_SEC cycles, independent of where the free-run count was.
module sec_prescaler #(
  parameter int TICKS_PER_SEC = 100
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [CW-1:0] TERM = CW'(TICKS_PER_SEC - 1);

  logic [CW-1:0] cnt;

  // With TICKS_PER_SEC=1 the count sits at 0 == TERM, so every cycle ticks.
  assign tick = (cnt == TERM);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)           cnt <= '0;
    else if (clr || tick) cnt <= '0;
    else                  cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/signal_sequencer.sv
// signal_sequencer: four-way traffic junction sequencer.
// Rotates green N -> E -> S -> W with per-road green times sampled from the
// adaptation block, a fixed yellow and a fixed all-red clearance between
// roads. A road with TG=0 is skipped inside all-red, so no lamp flickers.
// Ports:
//   clk   - clock, all state changes on rising edge
//   reset - asynchronous active-low reset
//   bus   - junction bus (master side), see signal_sequencer_if
// Timing:
//   - every state change clears the prescaler and loads the seconds counter,
//     so a phase of N seconds is exactly N*TICKS_PER_SEC cycles
//   - a phase ends on the second tick that takes the counter from 1 to 0
//   - load_req/cycle_done are registered, so they appear in the first cycle
//     of the new next_road value
module signal_sequencer
  import signal_sequencer_pkg::*;
#(
  parameter int TICKS_PER_SEC = 100,
  parameter int YELLOW_SEC    = 3,
  parameter int ALLRED_SEC    = 1
) (
  input  logic               clk,
  input  logic               reset,
  signal_sequencer_if.master bus
);

  localparam logic [SEC_W-1:0] YEL_LD = SEC_W'(YELLOW_SEC);
  localparam logic [SEC_W-1:0] AR_LD  = SEC_W'(ALLRED_SEC);

  state_t           state, state_nxt;
  road_t            cur_road, cur_nxt;
  road_t            next_road, next_nxt;
  logic [SEC_W-1:0] sec_cnt, sec_nxt;
  logic             load_req, load_req_nxt;
  logic             cycle_done, cycle_done_nxt;
  logic             entry;
  logic             sec_tick;
  logic             expire;
  logic [7:0]       tg_sel;

  sec_prescaler #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .clr  (entry),
    .tick (sec_tick)
  );

  // Green time of the road about to be served.
  always_comb begin
    tg_sel = bus.TGn;
    case (next_road)
      ROAD_N: tg_sel = bus.TGn;
      ROAD_E: tg_sel = bus.TGe;
      ROAD_S: tg_sel = bus.TGs;
      ROAD_W: tg_sel = bus.TGw;
    endcase
  end

  assign expire = sec_tick && (sec_cnt == SEC_W'(1));

  always_comb begin
    state_nxt      = state;
    cur_nxt        = cur_road;
    next_nxt       = next_road;
    sec_nxt        = sec_cnt;
    entry          = 1'b0;
    load_req_nxt   = 1'b0;
    cycle_done_nxt = 1'b0;

    if (sec_tick && (sec_cnt != '0)) sec_nxt = sec_cnt - SEC_W'(1);

    case (state)
      ST_IDLE: begin
        if (bus.enable) begin
          state_nxt = ST_ALLRED;
          entry     = 1'b1;
          sec_nxt   = AR_LD;
        end
      end

      // Dropping enable cuts green short but never skips yellow.
      ST_GREEN: begin
        if (!bus.enable || expire) begin
          state_nxt      = ST_YELLOW;
          entry          = 1'b1;
          sec_nxt        = YEL_LD;
          cycle_done_nxt = (cur_road == ROAD_W);
        end
      end

      // Yellow always runs to completion.
      ST_YELLOW: begin
        if (expire) begin
          state_nxt = ST_ALLRED;
          entry     = 1'b1;
          sec_nxt   = AR_LD;
        end
      end

      ST_ALLRED: begin
        if (expire) begin
          entry = 1'b1;
          if (!bus.enable) begin
            // next_road is kept so re-enabling resumes the rotation.
            state_nxt = ST_IDLE;
            sec_nxt   = '0;
          end else begin
            next_nxt     = road_inc(next_road);
            load_req_nxt = 1'b1;
            if (tg_sel != 8'd0) begin
              state_nxt = ST_GREEN;
              cur_nxt   = next_road;
              sec_nxt   = tg_sel;
            end else begin
              // Skip: spend another clearance period on the following road.
              sec_nxt        = AR_LD;
              cycle_done_nxt = (next_road == ROAD_W);
            end
          end
        end
      end

      default: begin
        state_nxt = ST_IDLE;
        entry     = 1'b1;
        sec_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      cur_road   <= ROAD_W;
      next_road  <= ROAD_N;
      sec_cnt    <= '0;
      load_req   <= 1'b0;
      cycle_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      cur_road   <= cur_nxt;
      next_road  <= next_nxt;
      sec_cnt    <= sec_nxt;
      load_req   <= load_req_nxt;
      cycle_done <= cycle_done_nxt;
    end
  end

  // Lamps decode straight from registered state, so reset blanks them at
  // once without waiting for a clock.
  assign bus.light_n    = light_for(state, cur_road, ROAD_N);
  assign bus.light_e    = light_for(state, cur_road, ROAD_E);
  assign bus.light_s    = light_for(state, cur_road, ROAD_S);
  assign bus.light_w    = light_for(state, cur_road, ROAD_W);
  assign bus.next_road  = next_road;
  assign bus.cur_road   = cur_road;
  assign bus.load_req   = load_req;
  assign bus.cycle_done = cycle_done;

endmodule
